// File: rtl/can_cfg_bridge_if.sv
// ---------------------------------------------------------------------------
// can_cfg_bridge_if
//
// Purpose: bundles the parser-side request/response handshake and the CAN
// wrapper configuration bus that the can_cfg_bridge sits between.
//
// Signal summary:
//   req_valid  1   parser request strobe
//   req_write  1   1 = write, 0 = read
//   req_addr   16  system address
//   req_wdata  32  write data
//   req_ready  1   bridge idle, request accepted on req_valid & req_ready
//   rsp_valid  1   one-cycle response pulse
//   rsp_rdata  32  read data (0 for writes and errors)
//   rsp_err    1   out-of-range or timeout
//   cfg_addr   16  address to the CAN wrapper
//   cfg_wdata  32  write data to the CAN wrapper
//   cfg_write  1   write strobe, held until ack
//   cfg_read   1   read strobe, held until ack
//   cfg_rdata  32  read data from the CAN wrapper
//   cfg_ack    1   access-complete handshake from the CAN wrapper
//
// Modports:
//   slave  - the bridge's view (receives requests, drives the cfg bus)
//   master - the surrounding environment (parser + CAN wrapper)
// ---------------------------------------------------------------------------
interface can_cfg_bridge_if;

  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_write;
  logic        cfg_read;
  logic [31:0] cfg_rdata;
  logic        cfg_ack;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output cfg_addr, cfg_wdata, cfg_write, cfg_read,
    input  cfg_rdata, cfg_ack
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  cfg_addr, cfg_wdata, cfg_write, cfg_read,
    output cfg_rdata, cfg_ack
  );

endinterface

// File: rtl/can_cfg_bridge.sv
// ---------------------------------------------------------------------------
// can_cfg_bridge
//
// Purpose: single-outstanding bridge from the command parser to the CAN
// wrapper configuration bus. A one-cycle request is range-checked against the
// CAN window; in-range accesses hold cfg_write/cfg_read until cfg_ack, then a
// one-cycle response carries read data and status back to the parser.
// Out-of-range requests are answered directly with an error and never touch
// the cfg bus.
//
// Ports:
//   clk    in   system clock, only clock of the block
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of can_cfg_bridge_if (request/response + cfg bus)
//
// Parameters:
//   BASE_ADDR       first system address of the CAN window
//   WINDOW          window size in bytes (window end computed in 17 bits)
//   TIMEOUT_CYCLES  ACCESS cycles without ack before the watchdog fires
//
// Build option:
//   CAN_CFG_BRIDGE_TIMEOUT_EN - when defined, a 16-bit watchdog ends accesses
//   that are never acknowledged with an error response. When undefined the
//   bridge waits in ACCESS indefinitely and no counter exists.
// ---------------------------------------------------------------------------
module can_cfg_bridge #(
  parameter logic [15:0] BASE_ADDR      = 16'h5000,
  parameter logic [15:0] WINDOW         = 16'h0100,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic             clk,
  input logic             rst_n,
  can_cfg_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // One bit wider than the address so a window ending at 16'hFFFF does not wrap.
  localparam logic [16:0] WindowEnd = {1'b0, BASE_ADDR} + {1'b0, WINDOW};

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        inRange;

`ifdef CAN_CFG_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdCnt_q, wdCnt_d;
`endif

  assign inRange = ({1'b0, bus.req_addr} >= {1'b0, BASE_ADDR}) &&
                   ({1'b0, bus.req_addr} <  WindowEnd);

  // Handshake and cfg outputs decode straight from the registered state, so an
  // asynchronous reset drops the strobes without waiting for a clock edge.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.cfg_addr  = addr_q;
  assign bus.cfg_wdata = wdata_q;
  assign bus.cfg_write = (state_q == ACCESS) &&  write_q;
  assign bus.cfg_read  = (state_q == ACCESS) && !write_q;

  // State and data registers; response fields only change when a response is
  // being prepared, so they hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef CAN_CFG_BRIDGE_TIMEOUT_EN
      wdCnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef CAN_CFG_BRIDGE_TIMEOUT_EN
      wdCnt_q <= wdCnt_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, wait for ack (or watchdog) in ACCESS,
  // and spend exactly one cycle in RESP before returning to IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef CAN_CFG_BRIDGE_TIMEOUT_EN
    wdCnt_d = wdCnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          if (inRange) begin
            state_d = ACCESS;
`ifdef CAN_CFG_BRIDGE_TIMEOUT_EN
            wdCnt_d = '0;
`endif
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end

      ACCESS: begin
        if (bus.cfg_ack) begin
          rdata_d = write_q ? 32'h0 : bus.cfg_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef CAN_CFG_BRIDGE_TIMEOUT_EN
        // An ack on the final watchdog edge takes priority over the timeout.
        else if (wdCnt_q == TimeoutLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wdCnt_d = wdCnt_q + 16'd1;
        end
`endif
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_can_cfg_bridge.sv
// ---------------------------------------------------------------------------
// tb_can_cfg_bridge
//
// Purpose: self-checking bench for can_cfg_bridge. A table of transactions
// (request fields, ack behaviour, expected response and strobe length) is run
// through a bus-level driver/monitor, followed by hand-written sequences for
// the ignored request / back-to-back case, reset during an access, and (when
// CAN_CFG_BRIDGE_TIMEOUT_EN is defined) the watchdog.
// ---------------------------------------------------------------------------
module tb_can_cfg_bridge;

  localparam int unsigned TbTimeout = 8;
  localparam int         MaxCycles = 40;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          ackDelay;
    logic        holdAck;
    logic [31:0] ackRdata;
    logic        expErr;
    logic [31:0] expRdata;
    int          expStrobes;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  can_cfg_bridge_if bus ();

  can_cfg_bridge #(
    .BASE_ADDR      (16'h5000),
    .WINDOW         (16'h0100),
    .TIMEOUT_CYCLES (TbTimeout)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 100 MHz bench clock; inputs change and outputs are sampled on falling edges.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Verifies every bridge output against its reset value.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    checkOutput({tag, "_rsp_err"},   32'(bus.rsp_err), 32'd0);
    checkOutput({tag, "_cfg_addr"},  32'(bus.cfg_addr), 32'd0);
    checkOutput({tag, "_cfg_wdata"}, bus.cfg_wdata, 32'd0);
    checkOutput({tag, "_cfg_write"}, 32'(bus.cfg_write), 32'd0);
    checkOutput({tag, "_cfg_read"},  32'(bus.cfg_read), 32'd0);
  endtask

  // Drives one request, plays the CAN wrapper (ack after ackDelay strobe
  // cycles, 0 = never, or ack held high throughout), and monitors strobes and
  // responses for a bounded number of cycles.
  task automatic applyStimulus(input vec_t v, output int strobes, output int wrong,
                               output int rspCount, output int rspCycle,
                               output logic err, output logic [31:0] rdata);
    int  postRsp;
    logic strobeNow;
    strobes  = 0;
    wrong    = 0;
    rspCount = 0;
    rspCycle = -1;
    err      = 1'b0;
    rdata    = 32'h0;
    postRsp  = 0;

    @(negedge clk);
    bus.cfg_ack   = v.holdAck;
    bus.cfg_rdata = v.ackRdata;
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'h0;
    bus.req_wdata = 32'h0;

    for (int cyc = 1; cyc <= MaxCycles && postRsp < 3; cyc++) begin
      strobeNow = bus.cfg_write | bus.cfg_read;
      if (strobeNow) begin
        strobes++;
        if (v.write ? bus.cfg_read : bus.cfg_write) wrong++;
        if (bus.cfg_addr != v.addr) wrong++;
        if (v.write && (bus.cfg_wdata != v.wdata)) wrong++;
      end
      if (bus.rsp_valid) begin
        rspCount++;
        if (rspCycle < 0) begin
          rspCycle = cyc;
          err      = bus.rsp_err;
          rdata    = bus.rsp_rdata;
        end
      end
      if (rspCount > 0) postRsp++;
      if (v.holdAck) bus.cfg_ack = 1'b1;
      else bus.cfg_ack = (v.ackDelay != 0) && strobeNow && (strobes == v.ackDelay);
      @(negedge clk);
    end
    bus.cfg_ack = 1'b0;
  endtask

  // Runs one table entry and compares every observed property with the record.
  task automatic runVector(input vec_t v, input string tag);
    int strobes, wrong, rspCount, rspCycle;
    logic err;
    logic [31:0] rdata;
    applyStimulus(v, strobes, wrong, rspCount, rspCycle, err, rdata);
    checkOutput({tag, "_rsp_count"},   32'(rspCount), 32'd1);
    checkOutput({tag, "_rsp_cycle"},   32'(rspCycle), 32'(v.expStrobes + 1));
    checkOutput({tag, "_strobes"},     32'(strobes), 32'(v.expStrobes));
    checkOutput({tag, "_strobe_bad"},  32'(wrong), 32'd0);
    checkOutput({tag, "_rsp_err"},     32'(err), 32'(v.expErr));
    checkOutput({tag, "_rsp_rdata"},   rdata, v.expRdata);
  endtask

  vec_t vecs[7];

  initial begin
    int rspSeen;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0;
    bus.req_wdata = 32'h0;
    bus.cfg_rdata = 32'h0;
    bus.cfg_ack   = 1'b0;

    //           write addr     wdata         ackDly hold  ackRdata      err   expRdata      strobes
    vecs[0] = '{1'b1, 16'h5008, 32'h0000_00A5, 3, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 3};
    vecs[1] = '{1'b0, 16'h5010, 32'h0000_0000, 1, 1'b1, 32'h1234_5678, 1'b0, 32'h1234_5678, 1};
    vecs[2] = '{1'b0, 16'h4FFF, 32'h0000_0000, 1, 1'b0, 32'hAAAA_AAAA, 1'b1, 32'h0000_0000, 0};
    vecs[3] = '{1'b1, 16'h5100, 32'h5555_5555, 1, 1'b0, 32'hAAAA_AAAA, 1'b1, 32'h0000_0000, 0};
    vecs[4] = '{1'b0, 16'h50FF, 32'h0000_0000, 2, 1'b0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 2};
    vecs[5] = '{1'b0, 16'h5000, 32'h0000_0000, 1, 1'b0, 32'h0000_0001, 1'b0, 32'h0000_0001, 1};
    vecs[6] = '{1'b1, 16'h50FE, 32'hF0F0_1234, 5, 1'b0, 32'h8765_4321, 1'b0, 32'h0000_0000, 5};

    // Reset state while rst_n is held low across a clock edge.
    @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) runVector(vecs[i], $sformatf("v%0d", i));

`ifdef CAN_CFG_BRIDGE_TIMEOUT_EN
    // Watchdog: no ack ends the access after TbTimeout strobe cycles with an
    // error; an ack on the last allowed cycle still completes normally.
    runVector('{1'b0, 16'h5060, 32'h0, 0, 1'b0, 32'h9999_9999, 1'b1, 32'h0, 8}, "wd_noack");
    runVector('{1'b0, 16'h5064, 32'h0, 8, 1'b0, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 8}, "wd_ack8");
`endif

    // Ignored request during ACCESS, then a request on the first ready cycle.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h5020;
    bus.req_wdata = 32'h0000_0020;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_strobe_c2", 32'(bus.cfg_write), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h5030;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("b2b_addr_kept", 32'(bus.cfg_addr), 32'h5020);
    checkOutput("b2b_no_read", 32'(bus.cfg_read), 32'd0);
    bus.cfg_ack = 1'b1;
    @(negedge clk);
    bus.cfg_ack = 1'b0;
    checkOutput("b2b_rsp1", 32'(bus.rsp_valid), 32'd1);
    checkOutput("b2b_ready_resp", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    checkOutput("b2b_single_rsp", 32'(bus.rsp_valid), 32'd0);
    checkOutput("b2b_ready_back", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h5040;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("b2b_second_read", 32'(bus.cfg_read), 32'd1);
    checkOutput("b2b_second_addr", 32'(bus.cfg_addr), 32'h5040);
    bus.cfg_rdata = 32'h0000_0077;
    bus.cfg_ack   = 1'b1;
    @(negedge clk);
    bus.cfg_ack = 1'b0;
    checkOutput("b2b_rsp2", 32'(bus.rsp_valid), 32'd1);
    checkOutput("b2b_rsp2_rdata", bus.rsp_rdata, 32'h0000_0077);
    @(negedge clk);
    checkOutput("b2b_idle", 32'(bus.req_ready), 32'd1);

    // Reset asserted in the middle of an access.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h5044;
    bus.req_wdata = 32'h1111_1111;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_strobe_before", 32'(bus.cfg_write), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkResetValues("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    rspSeen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.cfg_write || bus.cfg_read) rspSeen++;
    end
    checkOutput("rst_no_rsp", 32'(rspSeen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_cfg_bridge.md
# can_cfg_bridge

Single-outstanding transaction bridge between the command parser and the CAN wrapper's configuration bus. It accepts one-cycle read/write requests, range-checks the system address against the CAN window, and holds `cfg_write`/`cfg_read` until the CAN wrapper returns `cfg_ack`. It then returns read data and status to the parser as a one-cycle response. An optional watchdog terminates accesses the CAN IP never acknowledges.

## Interface
Parameters:
- `BASE_ADDR`, 16'h5000, first system address of the CAN window.
- `WINDOW`, 16'h0100, window size in bytes; the in-range test is `BASE_ADDR <= addr < BASE_ADDR+WINDOW`, evaluated in 17-bit arithmetic.
- `TIMEOUT_CYCLES`, 1024, maximum ACCESS-state cycles without ack (range 2..65535); used only when the watchdog is compiled in.

Ports:
- `clk`  in  1  system clock (50 MHz); the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  parser request strobe.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  system address.
- `req_wdata`  in  32  write data.
- `req_ready`  out  1  bridge idle; a request is accepted on `req_valid & req_ready`.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_err`  out  1  1 = out-of-range or timeout.
- `cfg_addr`  out  16  system address to the CAN wrapper.
- `cfg_wdata`  out  32  write data to the CAN wrapper.
- `cfg_write`  out  1  write strobe, level, held until ack.
- `cfg_read`  out  1  read strobe, level, held until ack.
- `cfg_rdata`  in  32  read data from the CAN wrapper.
- `cfg_ack`  in  1  access-complete handshake from the CAN wrapper.

## Operation
- **States.** IDLE, ACCESS, RESP (2-bit encoding).
- **IDLE.**
  - `req_ready` = 1.
  - On acceptance, latch addr, wdata and write.
  - In range: go to ACCESS.
  - Out of range: go straight to RESP with err = 1. No cfg strobe is ever asserted.
- **ACCESS.**
  - Exactly one of `cfg_write`/`cfg_read` = 1, per the latched `req_write`.
  - `cfg_addr`/`cfg_wdata` are driven from the latched registers and stay stable for the whole state.
  - `req_ready` = 0.
  - When `cfg_ack` is sampled high: capture `cfg_rdata` if the access is a read (0 if a write), set err = 0, go to RESP.
- **RESP.**
  - `rsp_valid` = 1 for exactly one cycle, with `rsp_rdata`/`rsp_err` valid in the same cycle.
  - Then go to IDLE unconditionally. The parser has no backpressure on the response.
- **Output registers.** `rsp_rdata`/`rsp_err` hold their values until the next RESP. `cfg_addr`/`cfg_wdata` hold their last values in IDLE. Strobes are 0 in every state except ACCESS.
- **Ignored inputs.**
  - `cfg_ack` outside ACCESS is ignored.
  - `req_valid` while `req_ready` = 0 is ignored and not queued.
- **Address arithmetic.** `BASE_ADDR + WINDOW` is computed in 17 bits, so a window ending at 16'hFFFF does not wrap.

## Timing
- **Reset values.** `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `cfg_addr` = 0, `cfg_wdata` = 0, `cfg_write` = 0, `cfg_read` = 0. State = IDLE, watchdog counter = 0.
- **Request to strobe.** Acceptance at edge E gives a strobe high from E+1.
- **Ack to response.** If `cfg_ack` is sampled at edge E+n (n ≥ 1), the strobe drops after E+n and `rsp_valid` is high in the cycle after E+n. The fastest round trip is `rsp_valid` in the cycle after E+1.
- **Out of range.** `rsp_valid` is high in the cycle after the accepting edge E.
- **Back-to-back.** `req_ready` returns to 1 in the cycle after the RESP cycle.
- **Mid-transaction reset.** Asserting `rst_n` mid-transaction drops the strobes asynchronously. The transaction is lost and no response is produced.

## Configuration
- **Macro:** `CAN_CFG_BRIDGE_TIMEOUT_EN`.
- **Defined.**
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - If no ack is sampled at the edge where the counter equals `TIMEOUT_CYCLES-1`, the strobes drop and the bridge goes to RESP with err = 1 and rdata = 0.
  - An ack sampled on that same edge wins, and the response is normal.
- **Undefined.** ACCESS waits indefinitely for `cfg_ack`; no counter logic is synthesised.

## Test plan
- **Write, ack after 3 cycles.** Write 16'h5008 / 32'h0000_00A5. Required: `cfg_write` high for exactly 3 cycles with addr/data stable, then `rsp_valid` for 1 cycle with `rsp_err` = 0 and `rsp_rdata` = 0.
- **Read, ack on first cycle.** Read 16'h5010 with `cfg_ack` tied high and `cfg_rdata` = 32'h1234_5678. Required: `cfg_read` high for 1 cycle, `rsp_rdata` = 32'h1234_5678, `rsp_valid` in the cycle after that edge.
- **Out-of-range addresses.**
  - 16'h4FFF: `rsp_err` = 1 and no strobe ever asserted.
  - 16'h5100: `rsp_err` = 1 and no strobe ever asserted.
  - 16'h50FF: normal access.
- **Timeout (macro on, `TIMEOUT_CYCLES` = 8, ack never given).**
  - Required: strobe high for exactly 8 cycles, then `rsp_err` = 1 and `rsp_rdata` = 0.
  - Repeat with ack on the 8th cycle: `rsp_err` = 0.
- **Ignored request, then back-to-back.** Pulse a second `req_valid` during ACCESS. Required: it is ignored and exactly one response is produced. A request presented on the first cycle `req_ready` returns to 1 is accepted.
- **Reset mid-access.** Assert `rst_n` mid-ACCESS. Required: strobes drop immediately, all outputs take their reset values, and no `rsp_valid` follows.
